// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: shares one asynchronous 8-bit SRAM between the display
// scanout (priority) and the MCU port. It maps (x, y) to a linear address and
// sequences the SRAM strobes.
module vram_arbiter #(
    parameter int WIDTH           = 320,
    parameter int HEIGHT          = 240,
    parameter int READ_CYCLES     = 2,
    parameter int WRITE_PULSE     = 2,
    parameter int MAX_READ_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        displayReadRequest,
    input  logic [8:0]  displayXCoord,
    input  logic [7:0]  displayYCoord,
    output logic [7:0]  displayReadData,
    output logic        displayReadComplete,
    input  logic        mcuReadRequest,
    input  logic        mcuWriteRequest,
    input  logic [8:0]  mcuXCoord,
    input  logic [7:0]  mcuYCoord,
    input  logic [7:0]  mcuWriteData,
    output logic [7:0]  mcuReadData,
    output logic        mcuReadComplete,
    output logic        mcuWriteComplete,
    output logic [16:0] sramAddress,
    output logic [7:0]  sramDataOut,
    output logic        sramDataDrive,
    input  logic [7:0]  sramDataIn,
    output logic        sramOutputEnableN,
    output logic        sramWriteEnableN
);

    localparam int MAX_PHASE = (READ_CYCLES > WRITE_PULSE) ? READ_CYCLES : WRITE_PULSE;
    localparam int CW        = $clog2(MAX_PHASE + 1);
    localparam int SW        = $clog2(MAX_READ_STREAK + 1);

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE} stateType;
    typedef enum logic [1:0] {OWN_DISPLAY, OWN_MCU_READ, OWN_MCU_WRITE} ownerType;

    stateType      state, stateNext;
    ownerType      owner;
    logic [CW-1:0] phaseCount;
    logic [SW-1:0] readStreak;

    logic          mcuPending, streakFull, grantMcu, grantDisplay, selInRange;
    logic [8:0]    selX;
    logic [7:0]    selY;
    logic [16:0]   selAddress;
    logic          readLast;

    // Starvation guard overrides display priority once the streak is saturated.
    always_comb begin
        mcuPending   = mcuReadRequest | mcuWriteRequest;
        streakFull   = (readStreak == SW'(MAX_READ_STREAK));
        grantMcu     = mcuPending && (streakFull || !displayReadRequest);
        grantDisplay = displayReadRequest && !grantMcu;
        selX         = grantMcu ? mcuXCoord : displayXCoord;
        selY         = grantMcu ? mcuYCoord : displayYCoord;
        selInRange   = (int'(selX) < WIDTH) && (int'(selY) < HEIGHT);
        selAddress   = 17'(selY) * 17'(WIDTH) + 17'(selX);
        readLast     = (state == READ) && (phaseCount == CW'(READ_CYCLES - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phaseCount <= '0;
        end else begin
            state      <= stateNext;
            phaseCount <= (stateNext == state) ? phaseCount + CW'(1) : '0;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantMcu || grantDisplay) begin
                    if (!selInRange)                   stateNext = DONE;
                    else if (grantMcu && mcuWriteRequest) stateNext = WR_SETUP;
                    else                                 stateNext = READ;
                end
            end
            READ:     if (readLast) stateNext = DONE;
            WR_SETUP: stateNext = WR_PULSE;
            WR_PULSE: if (phaseCount == CW'(WRITE_PULSE - 1)) stateNext = WR_HOLD;
            WR_HOLD:  stateNext = DONE;
            DONE:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sramAddress     <= '0;
            sramDataOut     <= '0;
            displayReadData <= '0;
            mcuReadData     <= '0;
            readStreak      <= '0;
            owner           <= OWN_DISPLAY;
        end else begin
            if (state == IDLE) begin
                if (grantMcu || !mcuPending)
                    readStreak <= '0;
                else if (grantDisplay && !streakFull)
                    readStreak <= readStreak + SW'(1);

                if (grantMcu || grantDisplay) begin
                    owner <= grantMcu ? (mcuWriteRequest ? OWN_MCU_WRITE : OWN_MCU_READ) : OWN_DISPLAY;
                    if (selInRange) begin
                        sramAddress <= selAddress;
                        if (grantMcu && mcuWriteRequest)
                            sramDataOut <= mcuWriteData;
                    end else if (grantDisplay) begin
                        displayReadData <= '0;
                    end else if (!mcuWriteRequest) begin
                        mcuReadData <= '0;
                    end
                end
            end

            if (readLast) begin
                if (owner == OWN_DISPLAY) displayReadData <= sramDataIn;
                else                      mcuReadData     <= sramDataIn;
            end
        end
    end

    always_comb begin
        sramOutputEnableN   = 1'b1;
        sramWriteEnableN    = 1'b1;
        sramDataDrive       = 1'b0;
        displayReadComplete = 1'b0;
        mcuReadComplete     = 1'b0;
        mcuWriteComplete    = 1'b0;
        case (state)
            READ:              sramOutputEnableN = 1'b0;
            WR_SETUP, WR_HOLD: sramDataDrive     = 1'b1;
            WR_PULSE: begin
                sramDataDrive    = 1'b1;
                sramWriteEnableN = 1'b0;
            end
            DONE: begin
                displayReadComplete = (owner == OWN_DISPLAY);
                mcuReadComplete     = (owner == OWN_MCU_READ);
                mcuWriteComplete    = (owner == OWN_MCU_WRITE);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: table-driven single transactions against an
// SRAM model, plus sequences for starvation, simultaneous requests and reset.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        displayReadRequest;
    logic [8:0]  displayXCoord;
    logic [7:0]  displayYCoord;
    logic [7:0]  displayReadData;
    logic        displayReadComplete;
    logic        mcuReadRequest;
    logic        mcuWriteRequest;
    logic [8:0]  mcuXCoord;
    logic [7:0]  mcuYCoord;
    logic [7:0]  mcuWriteData;
    logic [7:0]  mcuReadData;
    logic        mcuReadComplete;
    logic        mcuWriteComplete;
    logic [16:0] sramAddress;
    logic [7:0]  sramDataOut;
    logic        sramDataDrive;
    logic [7:0]  sramDataIn;
    logic        sramOutputEnableN;
    logic        sramWriteEnableN;

    always #5 clock = ~clock;

    vram_arbiter #(
        .WIDTH(320), .HEIGHT(240), .READ_CYCLES(2), .WRITE_PULSE(2), .MAX_READ_STREAK(4)
    ) dut (
        .clock(clock), .reset(reset),
        .displayReadRequest(displayReadRequest), .displayXCoord(displayXCoord),
        .displayYCoord(displayYCoord), .displayReadData(displayReadData),
        .displayReadComplete(displayReadComplete),
        .mcuReadRequest(mcuReadRequest), .mcuWriteRequest(mcuWriteRequest),
        .mcuXCoord(mcuXCoord), .mcuYCoord(mcuYCoord), .mcuWriteData(mcuWriteData),
        .mcuReadData(mcuReadData), .mcuReadComplete(mcuReadComplete),
        .mcuWriteComplete(mcuWriteComplete),
        .sramAddress(sramAddress), .sramDataOut(sramDataOut), .sramDataDrive(sramDataDrive),
        .sramDataIn(sramDataIn), .sramOutputEnableN(sramOutputEnableN),
        .sramWriteEnableN(sramWriteEnableN)
    );

    // SRAM model: data bus floats (0xEE) unless OE_n is low; writes land while WE_n is low.
    logic [7:0]  mem [0:76799];
    logic        presetEn = 1'b0;
    logic [16:0] presetAddr = '0;
    logic [7:0]  presetVal = '0;

    assign sramDataIn = sramOutputEnableN ? 8'hEE : mem[sramAddress];

    always @(posedge clock) begin
        if (presetEn) mem[presetAddr] <= presetVal;
        else if (!sramWriteEnableN && sramDataDrive) mem[sramAddress] <= sramDataOut;
    end

    int bothLow = 0;
    int driveWithOe = 0;
    always @(negedge clock) begin
        if (!sramOutputEnableN && !sramWriteEnableN) bothLow++;
        if (sramDataDrive && !sramOutputEnableN) driveWithOe++;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic presetMem(input logic [16:0] a, input logic [7:0] v);
        @(posedge clock); #1;
        presetAddr = a; presetVal = v; presetEn = 1'b1;
        @(posedge clock); #1;
        presetEn = 1'b0;
    endtask

    task automatic dropAll();
        displayReadRequest = 1'b0;
        mcuReadRequest     = 1'b0;
        mcuWriteRequest    = 1'b0;
    endtask

    typedef struct {
        bit          isMcu;
        bit          isWrite;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [7:0]  wdata;
        bit          preset;
        logic [7:0]  presetVal;
        logic [16:0] expAddr;
        int          expLat;
        logic [7:0]  expData;
        int          expOe;
        int          expWe;
        int          expDrv;
    } vecT;

    task automatic runVector(input string tag, input vecT v);
        int lat = -1, oeCnt = 0, weCnt = 0, drvCnt = 0, addrBad = 0, wrong = 0;
        logic own, other;
        logic [7:0] data = '0;
        if (v.preset) presetMem(v.expAddr, v.presetVal);
        @(posedge clock); #1;
        if (!v.isMcu) begin
            displayXCoord = v.x; displayYCoord = v.y; displayReadRequest = 1'b1;
        end else begin
            mcuXCoord = v.x; mcuYCoord = v.y; mcuWriteData = v.wdata;
            if (v.isWrite) mcuWriteRequest = 1'b1;
            else           mcuReadRequest  = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!sramOutputEnableN) oeCnt++;
            if (!sramWriteEnableN)  weCnt++;
            if (sramDataDrive)      drvCnt++;
            if ((!sramOutputEnableN || !sramWriteEnableN || sramDataDrive) && sramAddress != v.expAddr)
                addrBad++;
            if (!v.isMcu) begin
                own = displayReadComplete; other = mcuReadComplete | mcuWriteComplete; data = displayReadData;
            end else if (v.isWrite) begin
                own = mcuWriteComplete; other = displayReadComplete | mcuReadComplete;
            end else begin
                own = mcuReadComplete; other = displayReadComplete | mcuWriteComplete; data = mcuReadData;
            end
            if (other) wrong++;
            if (own) begin
                lat = k;
                dropAll();
                break;
            end
            @(posedge clock); #1;
        end
        dropAll();
        @(negedge clock);
        if (!v.isMcu)      own = displayReadComplete;
        else if (v.isWrite) own = mcuWriteComplete;
        else               own = mcuReadComplete;
        check({tag, " pulse width"}, int'(own), 0);
        @(posedge clock); #1;
        check({tag, " latency"}, lat, v.expLat);
        check({tag, " OE low cycles"}, oeCnt, v.expOe);
        check({tag, " WE low cycles"}, weCnt, v.expWe);
        check({tag, " drive cycles"}, drvCnt, v.expDrv);
        check({tag, " foreign complete"}, wrong, 0);
        if (v.expOe + v.expWe > 0) check({tag, " address"}, addrBad, 0);
        if (!v.isWrite) check({tag, " read data"}, int'(data), int'(v.expData));
        if (v.isWrite && v.expWe > 0) check({tag, " memory"}, int'(mem[v.expAddr]), int'(v.wdata));
    endtask

    task automatic starvationTest();
        int dispDone = 0, beforeWrite = -1, beforeRead = -1;
        bit reraise = 1'b0, finished = 1'b0;
        logic [7:0] rd = '0;
        @(posedge clock); #1;
        displayXCoord = 9'd3; displayYCoord = 8'd0; displayReadRequest = 1'b1;
        mcuXCoord = 9'd5; mcuYCoord = 8'd0; mcuWriteData = 8'h77; mcuWriteRequest = 1'b1;
        for (int k = 0; k < 200 && !finished; k++) begin
            @(negedge clock);
            if (reraise) begin displayReadRequest = 1'b1; reraise = 1'b0; end
            if (displayReadComplete) begin dispDone++; displayReadRequest = 1'b0; reraise = 1'b1; end
            if (mcuWriteComplete) begin beforeWrite = dispDone; mcuWriteRequest = 1'b0; mcuReadRequest = 1'b1; end
            if (mcuReadComplete) begin
                beforeRead = dispDone; rd = mcuReadData;
                dropAll(); reraise = 1'b0; finished = 1'b1;
            end
        end
        dropAll();
        repeat (3) @(posedge clock);
        #1;
        check("streak display grants before MCU write", beforeWrite, 4);
        check("streak display grants before MCU read", beforeRead, 8);
        check("streak MCU read-back", int'(rd), 8'h77);
    endtask

    task automatic simultaneousTest();
        int dispAt = -1, mcuAt = -1;
        logic [7:0] dd = '0, md = '0;
        presetMem(17'd10, 8'h31);
        presetMem(17'd11, 8'h62);
        @(posedge clock); #1;
        displayXCoord = 9'd10; displayYCoord = 8'd0; displayReadRequest = 1'b1;
        mcuXCoord = 9'd11; mcuYCoord = 8'd0; mcuReadRequest = 1'b1;
        for (int k = 0; k < 30 && (dispAt < 0 || mcuAt < 0); k++) begin
            @(negedge clock);
            if (displayReadComplete) begin dispAt = k; dd = displayReadData; displayReadRequest = 1'b0; end
            if (mcuReadComplete) begin mcuAt = k; md = mcuReadData; mcuReadRequest = 1'b0; end
            @(posedge clock); #1;
        end
        dropAll();
        repeat (2) @(posedge clock);
        #1;
        check("simultaneous display complete cycle", dispAt, 3);
        check("simultaneous MCU complete cycle", mcuAt, 7);
        check("simultaneous display data", int'(dd), 8'h31);
        check("simultaneous MCU data", int'(md), 8'h62);
    endtask

    task automatic resetMidWriteTest();
        int completes = 0;
        presetMem(17'd20, 8'h00);
        @(posedge clock); #1;
        mcuXCoord = 9'd20; mcuYCoord = 8'd0; mcuWriteData = 8'h99; mcuWriteRequest = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        check("reset test WE low before reset", int'(sramWriteEnableN), 0);
        reset = 1'b1;
        #1;
        check("reset mid-write WE_n", int'(sramWriteEnableN), 1);
        check("reset mid-write drive", int'(sramDataDrive), 0);
        check("reset mid-write OE_n", int'(sramOutputEnableN), 1);
        check("reset mid-write address", int'(sramAddress), 0);
        dropAll();
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (displayReadComplete || mcuReadComplete || mcuWriteComplete) completes++;
        end
        check("reset aborted complete pulses", completes, 0);
        check("reset aborted write memory", int'(mem[20]), 0);
        check("reset display read data", int'(displayReadData), 0);
        check("reset MCU read data", int'(mcuReadData), 0);
        runVector("post-reset read", '{1'b0, 1'b0, 9'd20, 8'd0, 8'h00, 1'b1, 8'h4D, 17'd20, 3, 8'h4D, 2, 0, 0});
    endtask

    vecT vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 9'd5,   8'd2,   8'h00, 1'b1, 8'hA5, 17'd645,   3, 8'hA5, 2, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 9'd319, 8'd239, 8'h3C, 1'b0, 8'h00, 17'd76799, 5, 8'h00, 0, 2, 4};
        vecs[2]  = '{1'b1, 1'b0, 9'd319, 8'd239, 8'h00, 1'b0, 8'h00, 17'd76799, 3, 8'h3C, 2, 0, 0};
        vecs[3]  = '{1'b1, 1'b1, 9'd320, 8'd0,   8'h55, 1'b0, 8'h00, 17'd0,     1, 8'h00, 0, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 9'd0,   8'd240, 8'h00, 1'b0, 8'h00, 17'd0,     1, 8'h00, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 8'h5A, 17'd0,     3, 8'h5A, 2, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 9'd100, 8'd200, 8'h00, 1'b1, 8'hC3, 17'd64100, 3, 8'hC3, 2, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 9'd319, 8'd240, 8'h00, 1'b0, 8'h00, 17'd0,     1, 8'h00, 0, 0, 0};
        vecs[8]  = '{1'b1, 1'b1, 9'd7,   8'd1,   8'hFF, 1'b0, 8'h00, 17'd327,   5, 8'h00, 0, 2, 4};
        vecs[9]  = '{1'b1, 1'b0, 9'd7,   8'd1,   8'h00, 1'b0, 8'h00, 17'd327,   3, 8'hFF, 2, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 9'd319, 8'd239, 8'h00, 1'b0, 8'h00, 17'd76799, 3, 8'h3C, 2, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 9'd511, 8'd0,   8'h00, 1'b0, 8'h00, 17'd0,     1, 8'h00, 0, 0, 0};

        reset = 1'b1;
        dropAll();
        displayXCoord = '0; displayYCoord = '0;
        mcuXCoord = '0; mcuYCoord = '0; mcuWriteData = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset OE_n", int'(sramOutputEnableN), 1);
        check("reset WE_n", int'(sramWriteEnableN), 1);
        check("reset drive", int'(sramDataDrive), 0);
        check("reset address", int'(sramAddress), 0);
        check("reset data out", int'(sramDataOut), 0);
        check("reset completes", int'({displayReadComplete, mcuReadComplete, mcuWriteComplete}), 0);
        check("reset read data", int'({displayReadData, mcuReadData}), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) runVector($sformatf("vec%0d", i), vecs[i]);

        starvationTest();
        simultaneousTest();
        resetMidWriteTest();

        check("OE_n and WE_n both low", bothLow, 0);
        check("drive while OE_n low", driveWithOe, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
